mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative 32-bit multiply/divide unit for the MIPS datapath, running alongside the ALU in the execute stage. It consumes register-file read data (rdA/rdB) as operands and holds results in architectural HI/LO registers. MFHI/MFLO write those registers back to the register file. One operation is in flight at a time. Fixed latency is 34 cycles, and busy/done handshakes let the control unit stall.

## Interface
Parameters:
- N, 32: operand and result width. Only 32 is supported; the iteration count equals N.

Ports:
- clock  in  1  rising-edge clock for all state.
- reset  in  1  synchronous, active-high.
- start  in  1  request. Sampled at rising edge; acted on only when idle.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO. 110 and 111 are no-ops.
- inA  in  N  multiplicand / dividend / MTHI-MTLO source.
- inB  in  N  multiplier / divisor.
- hi  out  N  HI register. Product upper half or remainder.
- lo  out  N  LO register. Product lower half or quotient.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when hi/lo have just been updated by MULT/DIV.

## Operation
States are IDLE, CALC and FIX, with a 6-bit iteration counter.

**IDLE**
- start=1 with op in {MULT, MULTU, DIV, DIVU}:
  - Latch absolute values of inA/inB (signed ops) or the raw values (unsigned ops).
  - Latch result signs: product sign = A31^B31; quotient sign = A31^B31; remainder sign = A31.
  - Clear the accumulator, set count=0, go to CALC.
- start=1 with MTHI: hi<=inA in that edge. Stay IDLE, no busy, no done.
- start=1 with MTLO: lo<=inA in that edge. Stay IDLE, no busy, no done.
- op 110/111: ignored.

**CALC**, one iteration per cycle, 32 cycles:
- Multiply: shift-add on a 64-bit {acc, multiplier} register.
  - If lsb=1, add the multiplicand to the upper half with carry-out.
  - Then shift the 65-bit value right by 1.
- Divide: restoring division.
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor from rem.
  - If non-negative, keep the difference and set quo lsb=1; else restore.
- After the 32nd iteration, go to FIX.

**FIX**, one cycle:
- Apply signs for signed ops:
  - Negate the 64-bit product if the product sign is set.
  - Negate the quotient if the quotient sign is set.
  - Negate the remainder if the remainder sign is set.
- Write hi/lo. Set done=1 for the following cycle. Go to IDLE.

**Width rules**
- Products are exact 64-bit results.
- DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps; no trap).

**Divide by zero (DIV or DIVU, inB=0)**
- Full 34-cycle latency.
- hi=inA as latched (original signed value), lo=0xFFFFFFFF.
- Sign fixup is suppressed.

**Boundaries**
- start while busy (CALC/FIX): ignored, including MTHI/MTLO. Operands are not re-sampled.
- inA/inB may change after the start edge without effect.
- hi/lo hold their previous values throughout CALC and change only at the FIX edge or on MTHI/MTLO.
- Reset at any time, including mid-operation:
  - Next edge gives state=IDLE, count=0, busy=0, done=0, hi=0, lo=0.
  - Reset has priority over start.

## Timing
- Start accepted at edge E0.
- busy=1 from after E0 through the cycle ending at E33; busy=0 after E33.
- CALC iterations occur at edges E1..E32; FIX write occurs at E33.
- done=1 exactly during the cycle after E33, with hi/lo valid in the same cycle.
- A new start may be sampled at E34 (busy=0, done=1 in that cycle). Back-to-back throughput is one operation per 34 cycles.
- MTHI/MTLO: hi/lo are visible the cycle after the start edge (1-cycle latency).
- busy and done are registered outputs with no combinational path from start.
- Reset values: hi=0, lo=0, busy=0, done=0.

## Structure
- Op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO) and state encodings go in constants.h, shared with the control unit's decoder.
- Single module with no sub-module. The multiply and divide iterations share the 64-bit working register and the 33-bit adder/subtractor, selected by a latched op-is-divide flag.
- Lives in library.v next to ALU.

## Test plan
- MULTU 0xFFFFFFFF×0xFFFFFFFF → at E33: hi=0xFFFFFFFE, lo=0x00000001. done pulses 1 cycle; busy high 33 cycles.
- MULT -7×6 → hi=0xFFFFFFFF, lo=0xFFFFFFD6. DIV -7/2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100/7 → lo=14, hi=2.
- DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0. DIVU 5/0 → lo=0xFFFFFFFF, hi=5, latency 34.
- Issue MULT 3×4; at E10 pulse start with DIV and new operands, and change inA/inB → ignored. Result is hi=0, lo=12 at E33.
- MTHI 0x1234 then MTLO 0x5678 in consecutive cycles → hi/lo update next cycle, busy and done stay 0. MTHI during busy → no effect.
- Assert reset at E15 of a DIV → next cycle busy=0, hi=lo=0, done never pulses. A new MULTU 2×3 started after reset yields lo=6 at its E33.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit. The op codes are
// the same values the control unit's decoder drives onto op.
package mul_div_unit_pkg;

   localparam logic [2:0] MD_MULT  = 3'b000;
   localparam logic [2:0] MD_MULTU = 3'b001;
   localparam logic [2:0] MD_DIV   = 3'b010;
   localparam logic [2:0] MD_DIVU  = 3'b011;
   localparam logic [2:0] MD_MTHI  = 3'b100;
   localparam logic [2:0] MD_MTLO  = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   // Signed ops take operand magnitudes and get a sign fixup at the end.
   function automatic logic is_signed_op(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the execute-stage control and mul_div_unit.
interface mul_div_unit_if #(parameter int N = 32);
   logic         start;
   logic [2:0]   op;
   logic [N-1:0] inA;
   logic [N-1:0] inB;
   logic [N-1:0] hi;
   logic [N-1:0] lo;
   logic         busy;
   logic         done;

   modport master (output start, op, inA, inB, input hi, lo, busy, done);
   modport slave  (input start, op, inA, inB, output hi, lo, busy, done);
endinterface

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide with HI/LO registers.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for start; MTHI/MTLO are written here directly
// S_CALC | one shift-add (mult) or restoring-divide step per cycle, N steps
// S_FIX  | apply result signs / divide-by-zero result, write hi/lo
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int N = 32
) (
   input logic           clock,
   input logic           reset,
   mul_div_unit_if.slave bus
);

   localparam logic [5:0] LAST_ITER = 6'(N - 1);

   state_t         state, state_nxt;
   logic [5:0]     count;
   logic [2*N-1:0] work;      // {acc, multiplier} or {rem, quo}
   logic [N-1:0]   opb_q;     // multiplicand or divisor magnitude
   logic [N-1:0]   a_orig;    // raw dividend, returned in hi on divide-by-zero
   logic           is_div, sign_q, sign_r, div_zero;
   logic [N-1:0]   hi_q, lo_q;
   logic           busy_q, done_q;

   logic           accept, move;
   logic           signed_op;
   logic [N-1:0]   abs_a, abs_b;
   logic [N-1:0]   mcand_sel;
   logic [N:0]     add_sum;
   logic [N:0]     div_top;
   logic           div_ge;
   logic [N-1:0]   div_diff;
   logic [2*N-1:0] work_nxt;
   logic [N-1:0]   fix_hi, fix_lo;

   // State register.
   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next state; start is only looked at while idle.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      move      = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.start && !bus.op[2]) begin
               accept    = 1'b1;
               state_nxt = S_CALC;
            end else if (bus.start && (bus.op == MD_MTHI || bus.op == MD_MTLO)) begin
               move = 1'b1;
            end
         end
         S_CALC:  if (count == LAST_ITER) state_nxt = S_FIX;
         S_FIX:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Operand magnitudes at the start edge.
   always_comb begin
      signed_op = is_signed_op(bus.op);
      abs_a     = (signed_op && bus.inA[N-1]) ? -bus.inA : bus.inA;
      abs_b     = (signed_op && bus.inB[N-1]) ? -bus.inB : bus.inB;
   end

   // One iteration. Divide compares against the N+1-bit shifted remainder
   // because it can exceed N bits when the divisor's top bit is set.
   always_comb begin
      mcand_sel = work[0] ? opb_q : {N{1'b0}};
      add_sum   = {1'b0, work[2*N-1:N]} + {1'b0, mcand_sel};
      div_top   = work[2*N-1:N-1];
      div_ge    = div_top >= {1'b0, opb_q};
      div_diff  = div_top[N-1:0] - opb_q;
      if (is_div)
         work_nxt = div_ge ? {div_diff, work[N-2:0], 1'b1} : {work[2*N-2:0], 1'b0};
      else
         work_nxt = {add_sum, work[N-1:1]};
   end

   // Final hi/lo values including sign fixup.
   always_comb begin
      fix_hi = work[2*N-1:N];
      fix_lo = work[N-1:0];
      if (div_zero) begin
         fix_hi = a_orig;
         fix_lo = {N{1'b1}};
      end else if (is_div) begin
         fix_lo = sign_q ? -work[N-1:0]   : work[N-1:0];
         fix_hi = sign_r ? -work[2*N-1:N] : work[2*N-1:N];
      end else if (sign_q) begin
         {fix_hi, fix_lo} = -work;
      end
   end

   // Datapath, HI/LO and handshake registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         count    <= '0;
         work     <= '0;
         opb_q    <= '0;
         a_orig   <= '0;
         is_div   <= 1'b0;
         sign_q   <= 1'b0;
         sign_r   <= 1'b0;
         div_zero <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  is_div   <= bus.op[1];
                  sign_q   <= signed_op & (bus.inA[N-1] ^ bus.inB[N-1]);
                  sign_r   <= signed_op & bus.inA[N-1];
                  div_zero <= bus.op[1] && (bus.inB == '0);
                  a_orig   <= bus.inA;
                  count    <= '0;
                  busy_q   <= 1'b1;
                  if (bus.op[1]) begin
                     work  <= {{N{1'b0}}, abs_a};
                     opb_q <= abs_b;
                  end else begin
                     work  <= {{N{1'b0}}, abs_b};
                     opb_q <= abs_a;
                  end
               end else if (move) begin
                  if (bus.op == MD_MTHI) hi_q <= bus.inA;
                  else                   lo_q <= bus.inA;
               end
            end
            S_CALC: begin
               work  <= work_nxt;
               count <= count + 6'd1;
            end
            S_FIX: begin
               hi_q   <= fix_hi;
               lo_q   <= fix_lo;
               done_q <= 1'b1;
               busy_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, hand-written
// corner sequences, then random operations against an arithmetic model.
module tb_mul_div_unit;
   import mul_div_unit_pkg::*;

   logic clock = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   mul_div_unit_if #(.N(32)) bus ();

   mul_div_unit #(.N(32)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Plain-arithmetic reference: returns {hi, lo}.
   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      case (op)
         MD_MULT: begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            p  = 64'(sa * sb);
            return p;
         end
         MD_MULTU: begin
            p = {32'b0, a} * {32'b0, b};
            return p;
         end
         MD_DIV: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
         end
         default: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
         end
      endcase
   endfunction

   // Drive one request; returns just after the accepting edge (E0 + 1).
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      bus.start = 1'b1;
      bus.op    = op;
      bus.inA   = a;
      bus.inB   = b;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
   endtask

   // Wait (bounded) for done; cyc = edges waited, bcnt = cycles seen busy.
   task automatic wait_done(output int cyc, output int bcnt);
      cyc  = 0;
      bcnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock);
         #1;
         cyc++;
         if (bus.done) break;
         if (bus.busy) bcnt++;
      end
      if (!bus.done) cyc = 99;
   endtask

   initial begin
      int          cyc, bcnt, dcnt;
      logic [63:0] exp;
      logic [2:0]  rop;
      logic [31:0] ra, rb;

      vecs[0] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[1] = '{MD_MULT,  32'hFFFF_FFF9, 32'd6,         32'hFFFF_FFFF, 32'hFFFF_FFD6};
      vecs[2] = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[3] = '{MD_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
      vecs[4] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
      vecs[5] = '{MD_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
      vecs[6] = '{MD_DIV,   32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF};
      vecs[7] = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
      vecs[8] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};

      bus.start = 1'b0;
      bus.op    = 3'b111;
      bus.inA   = '0;
      bus.inB   = '0;
      reset     = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      check("reset_hi",   {32'b0, bus.hi}, 64'd0);
      check("reset_lo",   {32'b0, bus.lo}, 64'd0);
      check("reset_busy", {63'b0, bus.busy}, 64'd0);
      check("reset_done", {63'b0, bus.done}, 64'd0);
      @(negedge clock);
      reset = 1'b0;

      // Directed vectors with latency checks.
      for (int i = 0; i < 9; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b);
         check($sformatf("v%0d_busy_e0", i), {63'b0, bus.busy}, 64'd1);
         bus.inA = $urandom;
         bus.inB = $urandom;
         wait_done(cyc, bcnt);
         check($sformatf("v%0d_latency", i), 64'(cyc), 64'd33);
         check($sformatf("v%0d_busycnt", i), 64'(bcnt), 64'd32);
         check($sformatf("v%0d_busy_at_done", i), {63'b0, bus.busy}, 64'd0);
         check($sformatf("v%0d_hilo", i), {bus.hi, bus.lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
         @(posedge clock);
         #1;
         check($sformatf("v%0d_done_pulse", i), {63'b0, bus.done}, 64'd0);
      end

      // MTHI then MTLO on consecutive cycles.
      issue(MD_MTHI, 32'h1234, 32'h0);
      check("mthi_hi",   {32'b0, bus.hi}, 64'h1234);
      check("mthi_busy", {62'b0, bus.busy, bus.done}, 64'd0);
      issue(MD_MTLO, 32'h5678, 32'h0);
      check("mtlo_lo",   {32'b0, bus.lo}, 64'h5678);
      check("mtlo_hi",   {32'b0, bus.hi}, 64'h1234);
      check("mtlo_busy", {62'b0, bus.busy, bus.done}, 64'd0);
      @(posedge clock);
      #1;
      check("mtlo_after", {62'b0, bus.busy, bus.done}, 64'd0);

      // No-op encoding leaves hi/lo alone.
      issue(3'b110, 32'hAAAA, 32'h5555);
      check("noop_hilo", {bus.hi, bus.lo}, {32'h1234, 32'h5678});
      check("noop_busy", {63'b0, bus.busy}, 64'd0);

      // MTHI while busy is ignored; hi/lo hold during CALC.
      issue(MD_MULTU, 32'd2, 32'd3);
      repeat (4) @(posedge clock);
      issue(MD_MTHI, 32'hDEAD, 32'h0);
      check("busy_mthi_hold", {bus.hi, bus.lo}, {32'h1234, 32'h5678});
      wait_done(cyc, bcnt);
      check("busy_mthi_result", {bus.hi, bus.lo}, {32'd0, 32'd6});

      // Start during CALC is ignored, operands changed afterwards too.
      issue(MD_MULT, 32'd3, 32'd4);
      repeat (9) @(posedge clock);
      issue(MD_DIV, 32'd100, 32'd7);
      bus.inA = 32'hFFFF_FFFF;
      bus.inB = 32'd0;
      check("ign_hold", {bus.hi, bus.lo}, {32'd0, 32'd6});
      wait_done(cyc, bcnt);
      check("ign_latency", 64'(cyc), 64'd23);
      check("ign_result",  {bus.hi, bus.lo}, {32'd0, 32'd12});

      // Reset mid-DIV.
      issue(MD_DIV, 32'd100, 32'd7);
      repeat (14) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check("rst_mid_busy", {63'b0, bus.busy}, 64'd0);
      check("rst_mid_hilo", {bus.hi, bus.lo}, 64'd0);
      @(negedge clock);
      reset = 1'b0;
      dcnt  = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock);
         #1;
         if (bus.done || bus.busy) dcnt++;
      end
      check("rst_mid_no_done", 64'(dcnt), 64'd0);
      issue(MD_MULTU, 32'd2, 32'd3);
      wait_done(cyc, bcnt);
      check("rst_after_lat", 64'(cyc), 64'd33);
      check("rst_after_res", {bus.hi, bus.lo}, {32'd0, 32'd6});

      // Random operations against the model.
      for (int i = 0; i < 40; i++) begin
         rop = 3'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom;
         if ($urandom_range(0, 7) == 0) rb = 32'd0;
         if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
         if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
         exp = model(rop, ra, rb);
         issue(rop, ra, rb);
         wait_done(cyc, bcnt);
         check($sformatf("rnd%0d_op%0d_%0h_%0h", i, rop, ra, rb), {bus.hi, bus.lo}, exp);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
